// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the MCP3304-style ADC sequencer.
//   state_t      : frame/sequencer states (IDLE, SETUP, SHIFT, DONE, GAP)
//   CH_*         : channel index constants for the four monitored quantities
//   FRAME_BITS   : clk_out periods per frame
//   CMD_BITS     : command bits (start, SGL/DIFF, D2, D1, D0)
//   DATA_BITS    : result width (sign + 12 bits)
//   build_cmd()  : assembles the command word for a channel
// Configuration macro: ADC_DIFF_EN selects pseudo-differential conversion
// (SGL/DIFF bit = 0); when undefined the conversion is single-ended.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [1:0] CH_VO   = 2'd0;
  localparam logic [1:0] CH_I    = 2'd1;
  localparam logic [1:0] CH_VIN  = 2'd2;
  localparam logic [1:0] CH_TEMP = 2'd3;

  localparam int FRAME_BITS = 21;
  localparam int CMD_BITS   = 5;
  localparam int DATA_BITS  = 13;

`ifdef ADC_DIFF_EN
  localparam logic SGL_BIT = 1'b0;
`else
  localparam logic SGL_BIT = 1'b1;
`endif

  // Command is sent MSB first: start, SGL/DIFF, D2, D1, D0.
  // Only four channels are used, so D2 is always 0.
  function automatic logic [CMD_BITS-1:0] build_cmd(input logic [1:0] ch);
    return {1'b1, SGL_BIT, 1'b0, ch};
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: runs a single SPI frame to the ADC.
//   clk, rst  : system clock, synchronous active-high reset
//   start     : one-cycle request to begin a frame (accepted only when idle)
//   ch        : channel index, captured with start
//   d_in      : ADC Dout
//   cs        : chip select, active low (registered)
//   clk_out   : SPI clock, idles low (registered)
//   d_out     : ADC Din, changes on clk_out falling edges or in SETUP
//   done      : high for the single DONE cycle; data is valid then
//   data      : 13-bit conversion result, MSB first as received
// Frame: SETUP (1 cycle) + 21 clk_out periods of 2*CLK_DIV cycles + DONE.
module adc_spi_frame
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           ch,
  input  logic                 d_in,
  output logic                 cs,
  output logic                 clk_out,
  output logic                 d_out,
  output logic                 done,
  output logic [DATA_BITS-1:0] data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] LAST_EDGE       = 5'(FRAME_BITS);
  localparam logic [4:0] FIRST_DATA_EDGE = 5'(FRAME_BITS - DATA_BITS + 1);

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [4:0]             edge_cnt;
  logic [CMD_BITS-1:0]    cmd_sr;
  logic [CMD_BITS-1:0]    cmd;
  logic [DATA_BITS-1:0]   data_sr;

  assign cmd  = build_cmd(ch);
  assign done = (state == DONE);
  assign data = data_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cs       <= 1'b1;
      clk_out  <= 1'b0;
      d_out    <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      cmd_sr   <= '0;
      data_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            cs      <= 1'b0;
            d_out   <= cmd[CMD_BITS-1];
            cmd_sr  <= {cmd[CMD_BITS-2:0], 1'b0};
            data_sr <= '0;
          end
        end
        SETUP: begin
          state    <= SHIFT;
          clk_out  <= 1'b1;
          edge_cnt <= 5'd1;
          div_cnt  <= '0;
        end
        SHIFT: begin
          // d_in is captured in the first cycle of each high phase, i.e. the
          // cycle in which clk_out rose; edge_cnt names the current edge.
          if (clk_out && (div_cnt == '0) && (edge_cnt >= FIRST_DATA_EDGE)) begin
            data_sr <= {data_sr[DATA_BITS-2:0], d_in};
          end
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (clk_out) begin
              // Falling edge: present the next command bit; the zero fill
              // keeps d_out low once the five command bits are out.
              clk_out <= 1'b0;
              d_out   <= cmd_sr[CMD_BITS-1];
              cmd_sr  <= {cmd_sr[CMD_BITS-2:0], 1'b0};
            end else if (edge_cnt == LAST_EDGE) begin
              state <= DONE;
              cs    <= 1'b1;
            end else begin
              clk_out  <= 1'b1;
              edge_cnt <= edge_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_top.sv
// adc_top: channel sequencer and result registers for a 13-bit serial ADC.
//   clk, rst  : system clock, synchronous active-high reset
//   hold      : suspend conversions at the next frame boundary
//   read_all  : 1 = scan ch0..ch3 round-robin, 0 = ch0 only
//   d_in      : ADC Dout;  d_out : ADC Din
//   cs        : ADC chip select (active low);  clk_out : SPI clock
//   adc_vo, adc_i, adc_vin, adc_temp : raw 13-bit two's-complement results
// Parameters: CLK_DIV (clk cycles per clk_out half period),
//             CS_HIGH (GAP cycles between frames).
// Configuration macro: ADC_DIFF_EN (pseudo-differential command, see adc_pkg).
module adc_top
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        read_all,
  input  logic        d_in,
  output logic        d_out,
  output logic        cs,
  output logic        clk_out,
  output logic [12:0] adc_vo,
  output logic [12:0] adc_i,
  output logic [12:0] adc_vin,
  output logic [12:0] adc_temp
);

  localparam int GAP_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH - 1);

  // The sequencer only needs IDLE, SHIFT (a frame is in flight in the
  // frame engine, covering its SETUP/SHIFT/DONE) and GAP.
  state_t                seq_state;
  logic [GAP_W-1:0]      gap_cnt;
  logic [1:0]            scan_idx;
  logic [1:0]            frame_ch;
  logic                  frame_scan;
  logic                  start;
  logic [1:0]            next_ch;
  logic                  frame_done;
  logic [DATA_BITS-1:0]  frame_data;

  assign next_ch = read_all ? scan_idx : CH_VO;
  assign start   = !hold && ((seq_state == IDLE) ||
                             ((seq_state == GAP) && (gap_cnt == GAP_LAST)));

  adc_spi_frame #(
    .CLK_DIV(CLK_DIV)
  ) u_frame (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ch      (next_ch),
    .d_in    (d_in),
    .cs      (cs),
    .clk_out (clk_out),
    .d_out   (d_out),
    .done    (frame_done),
    .data    (frame_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_state  <= IDLE;
      gap_cnt    <= '0;
      scan_idx   <= '0;
      frame_ch   <= CH_VO;
      frame_scan <= 1'b0;
      adc_vo     <= '0;
      adc_i      <= '0;
      adc_vin    <= '0;
      adc_temp   <= '0;
    end else begin
      case (seq_state)
        IDLE: begin
          if (start) seq_state <= SHIFT;
        end
        SHIFT: begin
          if (frame_done) begin
            seq_state <= GAP;
            gap_cnt   <= '0;
            case (frame_ch)
              CH_VO:   adc_vo   <= frame_data;
              CH_I:    adc_i    <= frame_data;
              CH_VIN:  adc_vin  <= frame_data;
              default: adc_temp <= frame_data;
            endcase
            // Only scan frames move the index, so a ch0-only frame never
            // disturbs where a later scan resumes.
            if (frame_scan) scan_idx <= scan_idx + 2'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            seq_state <= start ? SHIFT : IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          seq_state <= IDLE;
        end
      endcase

      // Channel and mode are latched as the frame enters SETUP.
      if (start) begin
        frame_ch   <= next_ch;
        frame_scan <= read_all;
        if (!read_all) scan_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_top.sv
// tb_adc_top: directed self-checking bench for adc_top with a behavioural
// ADC model that decodes the command stream and returns a per-channel code.
module tb_adc_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        read_all;
  logic        d_in = 1'b0;
  logic        d_out;
  logic        cs;
  logic        clk_out;
  logic [12:0] adc_vo;
  logic [12:0] adc_i;
  logic [12:0] adc_vin;
  logic [12:0] adc_temp;

  int checks = 0;
  int errors = 0;

  logic [12:0] ch_data [4];
  logic [12:0] exp_res [4];
  logic        force_one = 1'b0;

  int          edge_cnt = 0;
  logic        prev_clk_out = 1'b0;
  logic [4:0]  cmd_cap = '0;
  logic [4:0]  last_cmd;
  logic        cs_low_seen;

`ifdef ADC_DIFF_EN
  localparam logic EXP_SGL = 1'b0;
`else
  localparam logic EXP_SGL = 1'b1;
`endif

  adc_top #(
    .CLK_DIV(1),
    .CS_HIGH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .read_all (read_all),
    .d_in     (d_in),
    .d_out    (d_out),
    .cs       (cs),
    .clk_out  (clk_out),
    .adc_vo   (adc_vo),
    .adc_i    (adc_i),
    .adc_vin  (adc_vin),
    .adc_temp (adc_temp)
  );

  always #5 clk = ~clk;

  // ADC model: counts clk_out rising edges within a frame, records the five
  // command bits and drives the data bits for edges 9..21 (sign first).
  always @(negedge clk) begin
    logic [12:0] word;
    if (cs !== 1'b0) begin
      edge_cnt = 0;
    end else if (clk_out === 1'b1 && prev_clk_out === 1'b0) begin
      edge_cnt++;
      if (edge_cnt <= 5) cmd_cap[5-edge_cnt] = d_out;
      if (edge_cnt == 5) last_cmd = cmd_cap;
    end
    word = ch_data[cmd_cap[1:0]];
    if (force_one) d_in = 1'b1;
    else if (cs === 1'b0 && edge_cnt >= 9 && edge_cnt <= 21) d_in = word[21-edge_cnt];
    else d_in = 1'b0;
    prev_clk_out = clk_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_vo"},   adc_vo,   exp_res[0]);
    check({tag, "_i"},    adc_i,    exp_res[1]);
    check({tag, "_vin"},  adc_vin,  exp_res[2]);
    check({tag, "_temp"}, adc_temp, exp_res[3]);
  endtask

  initial begin
    rst      = 1'b1;
    hold     = 1'b0;
    read_all = 1'b0;
    ch_data  = '{13'h0ABC, 13'h0000, 13'h0000, 13'h0000};
    exp_res  = '{13'h0000, 13'h0000, 13'h0000, 13'h0000};

    // Reset state
    step(5);
    check("rst_cs", cs, 1'b1);
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_d_out", d_out, 1'b0);
    check_results("rst");

    // ch0-only frame: cs falls one cycle after reset release
    rst = 1'b0;
    step(1);
    check("first_cs_fall", cs, 1'b0);
    step(43);
    check("f1_done_cs", cs, 1'b1);
    check("f1_done_clk_out", clk_out, 1'b0);
    check("f1_vo_pending", adc_vo, 13'h0000);
    check("f1_cmd", last_cmd, {1'b1, EXP_SGL, 3'b000});
    step(1);
    exp_res[0] = 13'h0ABC;
    check_results("f1");
    step(1);
    check("f1_gap_cs", cs, 1'b1);

    // Switch to scanning during GAP; next frame starts 46 cycles after the first
    read_all = 1'b1;
    ch_data  = '{13'h0111, 13'h0222, 13'h0333, 13'h0444};
    step(1);
    check("period46_cs_fall", cs, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(43);
      check($sformatf("scan%0d_cmd", k), last_cmd, {1'b1, EXP_SGL, 1'b0, 2'(k)});
      step(1);
      exp_res[k] = ch_data[k];
      check_results($sformatf("scan%0d", k));
      step(2);
      check($sformatf("scan%0d_next_cs", k), cs, 1'b0);
    end

    // Scan wraps to ch0; hold raised mid-frame lets the frame finish
    ch_data[0] = 13'h0555;
    step(10);
    hold = 1'b1;
    step(33);
    check("hold_done_cs", cs, 1'b1);
    check("wrap_cmd", last_cmd, {1'b1, EXP_SGL, 3'b000});
    step(1);
    exp_res[0] = 13'h0555;
    check_results("hold_frame");
    cs_low_seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (cs !== 1'b1) cs_low_seen = 1'b1;
    end
    check("hold_cs_high", cs_low_seen, 1'b0);
    check_results("hold_stable");

    // Release hold: resumes at ch1
    ch_data[1] = 13'h0666;
    hold = 1'b0;
    step(1);
    check("resume_cs_fall", cs, 1'b0);
    step(43);
    check("resume_cmd", last_cmd, {1'b1, EXP_SGL, 3'b001});
    step(1);
    exp_res[1] = 13'h0666;
    check_results("resume");

    // Reset in the middle of the ch2 frame
    step(2);
    check("ch2_cs_fall", cs, 1'b0);
    step(15);
    rst = 1'b1;
    step(1);
    check("midrst_cs", cs, 1'b1);
    check("midrst_clk_out", clk_out, 1'b0);
    check("midrst_d_out", d_out, 1'b0);
    exp_res = '{13'h0000, 13'h0000, 13'h0000, 13'h0000};
    check_results("midrst");
    step(1);
    rst = 1'b0;
    step(1);
    check("restart_cs_fall", cs, 1'b0);
    step(43);
    check("restart_cmd", last_cmd, {1'b1, EXP_SGL, 3'b000});
    step(1);
    exp_res[0] = 13'h0555;
    check_results("restart");

    // d_in stuck high: all-ones code (-1); SGL bit follows the build option
    read_all  = 1'b0;
    force_one = 1'b1;
    step(2);
    check("ones_cs_fall", cs, 1'b0);
    step(43);
    check("ones_sgl", last_cmd[3], EXP_SGL);
    check("ones_cmd", last_cmd, {1'b1, EXP_SGL, 3'b000});
    step(1);
    exp_res[0] = 13'h1FFF;
    check_results("ones");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_top.md
# adc_top

SPI master and channel sequencer for a 13-bit, MCP3304-style serial ADC in the SMPS control loop. It converts four monitored quantities: output voltage, inductor current, input voltage and temperature. Each quantity gets a dedicated 13-bit result register. Output voltage can be sampled alone for a fast control loop, or all four channels can be scanned round-robin.

## Interface
Parameters:
- CLK_DIV, 1, clk cycles per clk_out half-period (≥1)
- CS_HIGH, 2, minimum clk cycles cs stays high between frames (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- hold  in  1  suspend conversions after the current frame; results frozen
- read_all  in  1  1: scan ch0..ch3 round-robin; 0: convert ch0 only
- d_in  in  1  serial data from ADC (Dout)
- d_out  out  1  serial command to ADC (Din)
- cs  out  1  ADC chip select, active low
- clk_out  out  1  SPI clock, idles low (mode 0,0)
- adc_vo  out  13  ch0 result (output voltage)
- adc_i  out  13  ch1 result (current)
- adc_vin  out  13  ch2 result (input voltage)
- adc_temp  out  13  ch3 result (temperature)

## Operation
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE: cs=1, clk_out=0. Goes to SETUP when hold=0.
- SETUP: lasts 1 cycle. cs=0 and d_out = first command bit.
- SHIFT: 21 clk_out periods.
  - Rising edges 1–5 carry the command: start=1, SGL (1), D2, D1, D0 = channel index.
  - Rising edges 6–7: sample period.
  - Rising edge 8: null bit.
  - Rising edges 9–21: 13 data bits, sign first, MSB-first.
- d_out changes only on clk_out falling edges, or in SETUP. It is 0 after the command bits.
- d_in is sampled on the clk_out rising edge, in the same clk cycle clk_out rises.
- DONE: lasts 1 cycle. cs=1 and clk_out=0. The 13-bit shift register is written to the channel's result register. All other result registers hold.
- GAP: CS_HIGH cycles. Then goes to SETUP if hold=0, else to IDLE.
- Channel select is latched at SETUP.
  - read_all=0: channel is 0.
  - read_all=1: channel is the scan index. The index advances 0→1→2→3→0 in DONE.
  - The index resets to 0 whenever a frame starts with read_all=0.
- hold is sampled only at frame boundaries (GAP exit / IDLE). A frame in progress always completes.
- Results are raw 13-bit two's-complement codes. No scaling is applied.

## Timing
- Reset values: cs=1, clk_out=0, d_out=0, all results 13'h0000, scan index 0, state IDLE.
- Reset mid-frame aborts the frame. The reset values appear on the cycle after the reset edge. No result is written.
- Frame length (cs fall to cs rise) = 1 + 42·CLK_DIV cycles.
- Frame period = 2 + 42·CLK_DIV + CS_HIGH. With defaults this is 46 clk cycles.
- First cs fall occurs one cycle after rst deasserts, provided hold=0.
- A result is visible on the cycle after the DONE edge. With defaults that is 44 cycles after cs falls.
- A read_all change mid-frame takes effect at the next SETUP.

## Configuration
- ADC_DIFF_EN defined: SGL/DIFF command bit = 0 (pseudo-differential pairs selected by D2..D0). Results may be negative.
- ADC_DIFF_EN undefined: SGL=1, single-ended conversion.
- Frame timing is identical in both cases.

## Structure
- Package adc_pkg:
  - state enum
  - channel index constants CH_VO=0, CH_I=1, CH_VIN=2, CH_TEMP=3
  - FRAME_BITS=21, CMD_BITS=5, DATA_BITS=13
- Sub-module adc_spi_frame: runs one cs/clk_out/d_out/d_in frame given a channel and start pulse. It returns the 13-bit data with a done pulse.
- adc_top holds the sequencer, hold/read_all logic and the result registers.

## Test plan
- Reset, then hold the bench in reset for 5 cycles → cs=1, clk_out=0, d_out=0, all four results 0.
- read_all=0, ADC model returns 13'h0ABC:
  - d_out command bits per frame are 1,1,0,0,0.
  - adc_vo=13'h0ABC 44 cycles after cs falls. Other results stay 0.
  - Frames repeat every 46 cycles.
- read_all=1, model returns 0x0111/0x0222/0x0333/0x0444 for ch0..3:
  - The four results are filled in order vo, i, vin, temp.
  - Command D2..D0 = 000, 001, 010, 011.
- hold=1 asserted mid-frame:
  - The frame completes and its result is written.
  - cs then stays 1 and results stay stable.
  - hold=0 resumes at the next scan channel.
- rst pulsed mid-frame → cs=1 on the next cycle and results cleared. Restart begins at ch0.
- d_in held at 1 with ADC_DIFF_EN defined → SGL bit 0 and result 13'h1FFF (−1).
